// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared definitions for the seven-segment display scanner:
//   - SEG_LUT   : 16-entry active-low segment encoding, bits {g,f,e,d,c,b,a}
//   - SEG_OFF   : all-off cathode pattern (segments and decimal point dark)
//   - seg_state_e : scanner FSM states
//   - seg_encode  : nibble -> active-low segment lookup
package seg_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n is the pattern for hex digit n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen
//   Slot timer and digit index for the display scanner. The slot counter
//   runs 0..TICK_DIV-1; on wrap the digit index advances 0..NUM_DIGITS-1.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (counter and index to 0)
//   idx        : current digit index
//   slot_start : first cycle of a slot (counter == 0)
//   slot_end   : last cycle of a slot (counter == TICK_DIV-1)
//   frame_wrap : last cycle of the last slot; index returns to 0 next cycle
module seg_tick_gen #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 50000,
  parameter int IW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          slot_start,
  output logic          slot_end,
  output logic          frame_wrap
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign slot_start = (cnt == '0);
  assign slot_end   = (cnt == CW'(TICK_DIV - 1));
  assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Multiplexed seven-segment display driver. New display data is captured
//   into a pending register on load and copied to the shadow register only
//   at the frame boundary, so a frame is never shown half old / half new.
//   Build option: define SEG_BLANKING_EN to blank all anodes for the first
//   BLANK_CYCLES cycles of every slot (anti-ghosting). Without it every slot
//   cycle drives its digit.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   value      : 4*NUM_DIGITS hex nibbles, nibble i -> digit i
//   digit_en   : per-digit enable, 0 blanks the digit
//   dp         : per-digit decimal point, 1 lights it
//   load       : one-cycle request to capture value/digit_en/dp
//   anodes     : active-low digit selects (registered)
//   cathodes   : active-low segments, bit0=a .. bit6=g, bit7=dp (registered)
//   frame_done : one-cycle pulse in the cycle the index wraps to 0
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              cathodes,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (TICK_DIV < 4 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_params
    $error("seg_display_scanner: TICK_DIV must be >= 4 and > BLANK_CYCLES");
  end

  logic [IW-1:0] idx;
  logic          slot_start;
  logic          slot_end;
  logic          frame_wrap;

  seg_tick_gen #(
    .NUM_DIGITS (NUM_DIGITS),
    .TICK_DIV   (TICK_DIV),
    .IW         (IW)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .slot_start (slot_start),
    .slot_end   (slot_end),
    .frame_wrap (frame_wrap)
  );

  // Slot sequencing keys off slot_end; slot_start is not needed here.
  logic unused_slot_start;
  assign unused_slot_start = slot_start;

  // Pending / shadow display data
  logic [4*NUM_DIGITS-1:0] pend_value, sh_value;
  logic [NUM_DIGITS-1:0]   pend_en, sh_en;
  logic [NUM_DIGITS-1:0]   pend_dp, sh_dp;
  logic                    pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_en    <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      sh_value   <= '0;
      sh_en      <= '0;
      sh_dp      <= '0;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_en    <= digit_en;
        pend_dp    <= dp;
      end
      if (frame_wrap) begin
        pend_valid <= 1'b0;
        // A load landing on the boundary cycle is newer than anything pending.
        if (load) begin
          sh_value <= value;
          sh_en    <= digit_en;
          sh_dp    <= dp;
        end else if (pend_valid) begin
          sh_value <= pend_value;
          sh_en    <= pend_en;
          sh_dp    <= pend_dp;
        end
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

  assign frame_done = frame_wrap & ~rst;

  // Slot FSM
  //   state    | meaning
  //   ST_BLANK | first BLANK_CYCLES cycles of a slot, anodes forced off
  //   ST_DRIVE | selected digit driven for the rest of the slot
  seg_state_e state;

`ifdef SEG_BLANKING_EN
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  logic [BW-1:0] blank_tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BLANK;
      blank_tmr <= BW'(BLANK_CYCLES - 1);
    end else if (slot_end) begin
      state     <= ST_BLANK;
      blank_tmr <= BW'(BLANK_CYCLES - 1);
    end else if (state == ST_BLANK) begin
      if (blank_tmr == '0) begin
        state <= ST_DRIVE;
      end else begin
        blank_tmr <= blank_tmr - BW'(1);
      end
    end
  end
`else
  assign state = ST_DRIVE;
`endif

  // Output registers: one cycle behind the index/state that selects them.
  logic [3:0] cur_nib;
  logic       drive_on;

  assign cur_nib  = sh_value[{idx, 2'b00} +: 4];
  assign drive_on = (state == ST_DRIVE) && sh_en[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      anodes   <= '1;
      cathodes <= SEG_OFF;
    end else if (drive_on) begin
      anodes   <= ~(NUM_DIGITS'(1) << idx);
      cathodes <= {~sh_dp[idx], seg_encode(cur_nib)};
    end else begin
      anodes   <= '1;
      cathodes <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Testbench for seg_display_scanner with NUM_DIGITS=8, TICK_DIV=4,
// BLANK_CYCLES=1. Inputs change and outputs are sampled on the falling edge.
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp;
  logic        load;
  logic [7:0]  anodes;
  logic [7:0]  cathodes;
  logic        frame_done;

`ifdef SEG_BLANKING_EN
  localparam bit BLANKING = 1'b1;
`else
  localparam bit BLANKING = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  // Data shown by the previous frame (its last cycle appears at step 1).
  logic [31:0] prev_v;
  logic [7:0]  prev_en, prev_dp;

  logic [7:0] obs_an  [1:32];
  logic [7:0] obs_cat [1:32];
  logic       obs_fd  [1:32];

  seg_display_scanner #(
    .NUM_DIGITS   (8),
    .TICK_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .anodes     (anodes),
    .cathodes   (cathodes),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7:0] exp_an(input logic [7:0] en, input int d, input bit blank);
    logic [7:0] one;
    one = 8'h01;
    return (en[d] && !blank) ? ~(one << d) : 8'hFF;
  endfunction

  function automatic logic [7:0] exp_cat(input logic [31:0] v, input logic [7:0] en,
                                         input logic [7:0] p, input int d, input bit blank);
    return (en[d] && !blank) ? {~p[d], hex7(v[d*4 +: 4])} : 8'hFF;
  endfunction

  // Expected {anodes, cathodes, frame_done} at step j after a frame_done edge.
  function automatic logic [16:0] frame_exp(input int j,
                                            input logic [31:0] cv, input logic [7:0] cen, cdp,
                                            input logic [31:0] pv, input logic [7:0] pen, pdp);
    int d;
    bit blank;
    if (j == 1)
      return {exp_an(pen, 7, 1'b0), exp_cat(pv, pen, pdp, 7, 1'b0), 1'b0};
    d = (j - 2) / 4;
    blank = BLANKING && (((j - 2) % 4) == 0);
    return {exp_an(cen, d, blank), exp_cat(cv, cen, cdp, d, blank), (j == 32)};
  endfunction

  task automatic idle_inputs();
    load     = 1'b0;
    value    = 32'h5A5A5A5A;
    digit_en = 8'hFF;
    dp       = 8'hFF;
  endtask

  // Steps one frame (32 falling edges), recording outputs and issuing loads.
  task automatic run_frame(input int la1, input logic [31:0] lv1, input logic [7:0] le1,
                           input logic [7:0] ld1, input int la2, input logic [31:0] lv2);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      obs_an[j]  = anodes;
      obs_cat[j] = cathodes;
      obs_fd[j]  = frame_done;
      if (j == la1) begin
        load = 1'b1; value = lv1; digit_en = le1; dp = ld1;
      end else if (j == la2) begin
        load = 1'b1; value = lv2; digit_en = le1; dp = ld1;
      end else begin
        idle_inputs();
      end
    end
  endtask

  task automatic set_prev(input logic [31:0] v, input logic [7:0] en, input logic [7:0] p);
    prev_v = v; prev_en = en; prev_dp = p;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (anodes !== 8'hFF) $display("FAIL reset_anodes got %h exp ff", anodes); else passed++;
    total++; if (cathodes !== 8'hFF) $display("FAIL reset_cathodes got %h exp ff", cathodes); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else passed++;
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      total++;
      if ({anodes, cathodes, frame_done} !== {8'hFF, 8'hFF, (k == 31)})
        $display("FAIL first_frame k=%0d got an=%h cat=%h fd=%b exp an=ff cat=ff fd=%b",
                 k, anodes, cathodes, frame_done, (k == 31));
      else passed++;
    end
    set_prev(32'h0, 8'h00, 8'h00);
  endtask

  task automatic test_dark_frames();
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 32'h0, 8'h0, 8'h0, -1, 32'h0);
      for (int j = 1; j <= 32; j++) begin
        logic [16:0] e;
        e = frame_exp(j, 32'h0, 8'h00, 8'h00, prev_v, prev_en, prev_dp);
        total++;
        if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
          $display("FAIL dark f=%0d j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                   f, j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
        else passed++;
      end
    end
  endtask

  task automatic test_load_basic();
    run_frame(10, 32'h76543210, 8'hFF, 8'h01, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'h0, 8'h00, 8'h00, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL load_wait j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    run_frame(-1, 32'h0, 8'h0, 8'h0, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'h76543210, 8'hFF, 8'h01, 32'h0, 8'h00, 8'h00);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL load_show j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    total++; if (obs_cat[3] !== 8'h40) $display("FAIL digit0_cat got %h exp 40", obs_cat[3]); else passed++;
    total++; if (obs_cat[15] !== 8'hB0) $display("FAIL digit3_cat got %h exp b0", obs_cat[15]); else passed++;
    total++; if (obs_an[3] !== 8'hFE) $display("FAIL digit0_an got %h exp fe", obs_an[3]); else passed++;
    total++; if (obs_an[31] !== 8'h7F) $display("FAIL digit7_an got %h exp 7f", obs_an[31]); else passed++;
    set_prev(32'h76543210, 8'hFF, 8'h01);
  endtask

  task automatic test_midframe_load();
    run_frame(5, 32'hFFFFFFFF, 8'hFF, 8'h00, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'h76543210, 8'hFF, 8'h01, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL mid_old j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    set_prev(32'h76543210, 8'hFF, 8'h01);
    run_frame(-1, 32'h0, 8'h0, 8'h0, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'hFFFFFFFF, 8'hFF, 8'h00, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL mid_new j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    total++; if (obs_cat[3] !== 8'h8E) $display("FAIL mid_digit0_cat got %h exp 8e", obs_cat[3]); else passed++;
    set_prev(32'hFFFFFFFF, 8'hFF, 8'h00);
  endtask

  task automatic test_back_to_back();
    run_frame(3, 32'h11111111, 8'hFF, 8'h00, 20, 32'h22222222);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'hFFFFFFFF, 8'hFF, 8'h00, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL b2b_old j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    set_prev(32'hFFFFFFFF, 8'hFF, 8'h00);
    // Load on the frame_done cycle (step 32) for the next test.
    run_frame(32, 32'hFEDCBA98, 8'h0F, 8'h5A, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'h22222222, 8'hFF, 8'h00, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL b2b_new j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    total++; if (obs_cat[3] !== 8'hA4) $display("FAIL b2b_digit0_cat got %h exp a4", obs_cat[3]); else passed++;
    total++; if (obs_cat[27] !== 8'hA4) $display("FAIL b2b_digit6_cat got %h exp a4", obs_cat[27]); else passed++;
    set_prev(32'h22222222, 8'hFF, 8'h00);
  endtask

  task automatic test_digit_en();
    run_frame(-1, 32'h0, 8'h0, 8'h0, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'hFEDCBA98, 8'h0F, 8'h5A, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL den j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    total++; if (obs_an[3] !== 8'hFE) $display("FAIL den_digit0_an got %h exp fe", obs_an[3]); else passed++;
    total++; if (obs_cat[3] !== 8'h80) $display("FAIL den_digit0_cat got %h exp 80", obs_cat[3]); else passed++;
    total++; if (obs_an[19] !== 8'hFF) $display("FAIL den_digit4_an got %h exp ff", obs_an[19]); else passed++;
    total++; if (obs_an[31] !== 8'hFF) $display("FAIL den_digit7_an got %h exp ff", obs_an[31]); else passed++;
    set_prev(32'hFEDCBA98, 8'h0F, 8'h5A);
  endtask

  task automatic test_reset_midframe();
    repeat (5) @(negedge clk);
    load = 1'b1; value = 32'h13579BDF; digit_en = 8'hFF; dp = 8'hFF;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({anodes, cathodes, frame_done} !== {8'hFF, 8'hFF, 1'b0})
      $display("FAIL rst_mid_dark got an=%h cat=%h fd=%b exp an=ff cat=ff fd=0", anodes, cathodes, frame_done);
    else passed++;
    @(negedge clk);
    total++;
    if ({anodes, cathodes, frame_done} !== {8'hFF, 8'hFF, 1'b0})
      $display("FAIL rst_mid_hold got an=%h cat=%h fd=%b exp an=ff cat=ff fd=0", anodes, cathodes, frame_done);
    else passed++;
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      total++;
      if ({anodes, cathodes, frame_done} !== {8'hFF, 8'hFF, (k == 31)})
        $display("FAIL rst_mid_frame k=%0d got an=%h cat=%h fd=%b exp an=ff cat=ff fd=%b",
                 k, anodes, cathodes, frame_done, (k == 31));
      else passed++;
    end
    set_prev(32'h0, 8'h00, 8'h00);
    // Pending load from before reset must not appear at this boundary.
    run_frame(10, 32'hC0FFEE01, 8'hFF, 8'h00, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'h0, 8'h00, 8'h00, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL rst_discard j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    run_frame(-1, 32'h0, 8'h0, 8'h0, -1, 32'h0);
    for (int j = 1; j <= 32; j++) begin
      logic [16:0] e;
      e = frame_exp(j, 32'hC0FFEE01, 8'hFF, 8'h00, prev_v, prev_en, prev_dp);
      total++;
      if ({obs_an[j], obs_cat[j], obs_fd[j]} !== e)
        $display("FAIL rst_reload j=%0d got an=%h cat=%h fd=%b exp an=%h cat=%h fd=%b",
                 j, obs_an[j], obs_cat[j], obs_fd[j], e[16:9], e[8:1], e[0]);
      else passed++;
    end
    total++; if (obs_cat[3] !== 8'hF9) $display("FAIL rst_reload_digit0 got %h exp f9", obs_cat[3]); else passed++;
  endtask

  initial begin
    test_reset();
    test_dark_frames();
    test_load_basic();
    test_midframe_load();
    test_back_to_back();
    test_digit_en();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed digits.
REQ-002 The block SHALL have parameter TICK_DIV, default 50000, meaning the clock cycles per digit slot (minimum 4).
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 2, meaning the dead cycles at slot start (used only with SEG_BLANKING_EN; must be less than TICK_DIV).
REQ-004 clk  in  1  is the single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 value  in  4*NUM_DIGITS  carries hex nibbles; nibble i is digit i.
REQ-007 digit_en  in  NUM_DIGITS  is the per-digit enable; 0 blanks that digit.
REQ-008 dp  in  NUM_DIGITS  is the per-digit decimal point; 1 lights it.
REQ-009 load  in  1  is a one-cycle pulse requesting capture of value/digit_en/dp.
REQ-010 anodes  out  NUM_DIGITS  are active-low digit selects.
REQ-011 cathodes  out  8  are active-low segments: bit0=a through bit6=g, bit7=dp.
REQ-012 frame_done  out  1  SHALL pulse for one cycle when the last slot completes.

Function
REQ-013 A slot counter SHALL count 0..TICK_DIV-1; at TICK_DIV-1 it SHALL wrap to 0 and advance the digit index (0..NUM_DIGITS-1, wrapping to 0).
REQ-014 During a drive cycle of digit i, anodes SHALL have only bit i low, and cathodes SHALL hold the encoding of shadow nibble i with bit7 = ~shadow_dp[i].
REQ-015 If shadow_en[i]=0, anodes SHALL be all 1 and cathodes all 1 for the whole slot.
REQ-016 anodes and cathodes SHALL be registered: they change exactly one cycle after the counter/index state that selects them.
REQ-017 Hex encoding (active low, {g..a}) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 load SHALL sample value/digit_en/dp into a pending register and set the pending flag; a later load before it is applied SHALL overwrite it (newest wins).
REQ-019 Pending contents SHALL be copied to the shadow only on the frame boundary (index NUM_DIGITS-1 → 0), so no frame is ever torn.
REQ-020 If load coincides with the frame boundary cycle, the newly sampled data SHALL be the data applied at that boundary.
REQ-021 frame_done SHALL assert in the cycle the index wraps to 0, coincident with the shadow update.
REQ-022 The FSM SHALL have states BLANK and DRIVE; BLANK→DRIVE after BLANK_CYCLES cycles, and DRIVE→BLANK at slot wrap.

Reset
REQ-023 On rst the counter, index, pending flag, shadow and pending registers SHALL be 0; anodes all 1; cathodes all 1; frame_done 0; FSM in BLANK (DRIVE without the macro).
REQ-024 rst mid-frame SHALL discard pending data; the display SHALL stay dark until the first load is applied at a frame boundary.

Configuration
REQ-025 With SEG_BLANKING_EN defined, the first BLANK_CYCLES cycles of each slot SHALL drive anodes all 1 (anti-ghosting) and the remaining TICK_DIV-BLANK_CYCLES cycles SHALL be DRIVE.
REQ-026 Without SEG_BLANKING_EN, there SHALL be no BLANK state; every slot cycle is DRIVE and anodes switch directly between digits.

Structure
REQ-027 Package seg_pkg SHALL hold the 16-entry segment encoding constant, the FSM state enum and the all-off cathode constant.
REQ-028 Sub-module seg_tick_gen SHALL implement the slot counter and digit index, emitting slot_start, slot_end and frame_wrap.

Verification (NUM_DIGITS=8, TICK_DIV=4, BLANK_CYCLES=1)
REQ-029 Reset is released with no load -> anodes=8'hFF and cathodes=8'hFF for 3 full frames; frame_done pulses every 32 cycles.
REQ-030 load with value=32'h76543210, digit_en=8'hFF, dp=8'h01 -> from the next frame, digit 0 shows cathodes=8'h40 and digit 3 shows 8'hB0; anodes step FE,FD,...,7F.
REQ-031 load mid-frame with value=32'hFFFFFFFF -> the current frame still shows the old value, and the first digit of the next frame shows 8'h8E.
REQ-032 Two loads in one frame (32'h11111111 then 32'h22222222) -> the next frame shows only 2 (8'hA4); a load on the frame_done cycle is applied immediately.
REQ-033 digit_en=8'h0F -> anodes are all 1 during slots 4-7; with SEG_BLANKING_EN, the first cycle of each slot has anodes=8'hFF.
REQ-034 rst asserted mid-frame with a pending load -> outputs go dark the next cycle and stay dark after release until a new load.
